// File: rtl/mod_accumulator_mc.sv
// Multi-channel modular accumulator bank with per-channel frame counting.
// Ports: iClk/iRstN clock and async reset, iClr sync clear, iQ modulus,
//   iLen beats per frame (0 = free-run), iValid/oReady/iChan/iSub/iData
//   input beat, oValid/iReady/oData/oChan completed-frame result,
//   iRdChan/oRdData combinational accumulator readback.
module mod_accumulator_mc #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 4,
    parameter int CHW      = 2,
    parameter int LENW     = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iQ,
    input  logic [LENW-1:0]     iLen,
    input  logic                iValid,
    output logic                oReady,
    input  logic [CHW-1:0]      iChan,
    input  logic                iSub,
    input  logic [BITWIDTH-1:0] iData,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData,
    output logic [CHW-1:0]      oChan,
    input  logic [CHW-1:0]      iRdChan,
    output logic [BITWIDTH-1:0] oRdData
);

    logic [BITWIDTH-1:0] acc [CHANNELS];
    logic [LENW-1:0]     cnt [CHANNELS];

    logic [BITWIDTH-1:0] cur_acc;
    logic [LENW-1:0]     cur_cnt;
    logic [LENW-1:0]     cnt_inc;
    logic [BITWIDTH-1:0] rd_mux;
    logic [BITWIDTH-1:0] result;
    logic [BITWIDTH:0]   wide_q;
    logic [BITWIDTH:0]   sum;
    logic [BITWIDTH:0]   sum_red;
    logic [BITWIDTH:0]   diff;
    logic [BITWIDTH:0]   diff_wrap;
    logic                fire;
    logic                done;

    // Full stall while a result is held; not channel-selective.
    assign oReady = ~oValid | iReady;
    assign fire   = iValid & oReady & ~iClr;

    // Channel compare loops keep out-of-range indices from touching storage.
    always_comb begin
        cur_acc = '0;
        cur_cnt = '0;
        rd_mux  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (iChan == CHW'(i)) begin
                cur_acc = acc[i];
                cur_cnt = cnt[i];
            end
            if (iRdChan == CHW'(i)) begin
                rd_mux = acc[i];
            end
        end
    end

    assign oRdData = rd_mux;

    assign wide_q    = {1'b0, iQ};
    assign sum       = {1'b0, cur_acc} + {1'b0, iData};
    assign sum_red   = sum - wide_q;
    assign diff      = {1'b0, cur_acc} - {1'b0, iData};
    assign diff_wrap = diff + wide_q;

    always_comb begin
        result = '0;
        if (iSub) begin
            if (cur_acc >= iData) begin
                result = diff[BITWIDTH-1:0];
            end else begin
                result = diff_wrap[BITWIDTH-1:0];
            end
        end else begin
            if (sum >= wide_q) begin
                result = sum_red[BITWIDTH-1:0];
            end else begin
                result = sum[BITWIDTH-1:0];
            end
        end
    end

    // Counter wraps naturally in free-run mode since iLen == 0 never matches.
    assign cnt_inc = cur_cnt + LENW'(1);
    assign done    = fire & (iLen != '0) & (cnt_inc == iLen);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            oValid <= 1'b0;
            oData  <= '0;
            oChan  <= '0;
        end else if (iClr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            oValid <= 1'b0;
            oData  <= '0;
            oChan  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (fire && (iChan == CHW'(i))) begin
                    acc[i] <= done ? '0 : result;
                    cnt[i] <= done ? '0 : cnt_inc;
                end
            end
            // A new completion wins over consumption of the held result.
            if (done) begin
                oValid <= 1'b1;
                oData  <= result;
                oChan  <= iChan;
            end else if (iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule
